// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, request/response structs and widths shared by the ALU stage
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_PC_W   = 32;
  localparam int ALU_RF_W   = 5;
  localparam int ALU_OFF_W  = 20;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_MUL  = 4'd3,
    OP_LDB  = 4'd4,
    OP_LDW  = 4'd5,
    OP_STB  = 4'd6,
    OP_STW  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_JUMP = 4'd9
  } alu_op_e;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } mem_size_e;

  typedef struct packed {
    alu_op_e               opcode;
    logic [ALU_DATA_W-1:0] ra_data;
    logic [ALU_DATA_W-1:0] rb_data;
    logic [ALU_OFF_W-1:0]  offset;
    logic [ALU_RF_W-1:0]   rd_addr;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [ALU_DATA_W-1:0] addr;
    logic                  is_store;
    mem_size_e             size;
    logic [ALU_RF_W-1:0]   rd_addr;
    logic                  m_type;
    logic                  r_type;
  } alu_rsp_t;

  // Per-stage side information that travels with a multiply.
  typedef struct packed {
    logic [ALU_RF_W-1:0] rd_addr;
    logic [ALU_PC_W-1:0] pc;
  } mul_tag_t;

endpackage

// File: rtl/alu_mul_pipe.sv
// rtl/alu_mul_pipe.sv - fully pipelined multiplier, one issue per cycle, valid+tag per stage
module alu_mul_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4,
  parameter type TAG_T     = logic
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  TAG_T                  i_tag,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output TAG_T                  o_tag
);

  // The consumer's output register supplies the last of the LATENCY cycles.
  localparam int STAGES = LATENCY - 1;

  logic [STAGES-1:0]     r_valid;
  logic [DATA_WIDTH-1:0] r_data [STAGES];
  TAG_T                  r_tag  [STAGES];
  logic [DATA_WIDTH-1:0] w_prod;

  assign w_prod = i_a * i_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_en) begin
      r_valid[0] <= i_valid;
      r_data[0]  <= w_prod;
      r_tag[0]   <= i_tag;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];
  assign o_tag   = r_tag[STAGES-1];

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - execute stage: ALU/AGU fast path, branch resolve, pipelined MUL, in-order output
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = ALU_DATA_W,
  parameter int PC_WIDTH      = ALU_PC_W,
  parameter int RF_ADDR_WIDTH = ALU_RF_W,
  parameter int OFFSET_WIDTH  = ALU_OFF_W,
  parameter int MUL_LATENCY   = 4,
  localparam int CNT_W        = $clog2(MUL_LATENCY + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  alu_req_t                 req_info,
  input  logic [PC_WIDTH-1:0]      req_pc,
  input  logic                     stall_in,
  input  logic                     flush,
  output logic                     rsp_valid,
  output alu_rsp_t                 rsp_info,
  output logic [PC_WIDTH-1:0]      rsp_pc,
  output logic                     take_branch,
  output logic [PC_WIDTH-1:0]      branch_pc,
  output logic                     bypass_valid,
  output logic [RF_ADDR_WIDTH-1:0] bypass_rd_addr,
  output logic [DATA_WIDTH-1:0]    bypass_data,
  output logic [CNT_W-1:0]         mul_inflight
);

  logic                    w_is_mul, w_mul_busy, w_accept, w_mul_issue;
  logic                    w_fast_valid, w_br_taken;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic [DATA_WIDTH-1:0]   w_imm;
  alu_rsp_t                w_fast_rsp, w_mul_rsp;
  mul_tag_t                w_issue_tag, w_mul_tag;
  logic                    w_mul_valid;
  logic [DATA_WIDTH-1:0]   w_mul_data;

  logic                    r_rsp_valid, r_rsp_mul, r_take_branch;
  alu_rsp_t                r_rsp_info;
  logic [PC_WIDTH-1:0]     r_rsp_pc, r_branch_pc;
  logic [CNT_W-1:0]        r_inflight;

  assign w_offset    = req_info.offset;
  assign w_imm       = DATA_WIDTH'(w_offset);
  assign w_is_mul    = (req_info.opcode == OP_MUL);
  assign w_mul_busy  = (r_inflight != '0);
  // A non-MUL waits for the multiplier to drain so completions stay in order.
  assign req_ready   = reset & ~stall_in & ~flush & ~(w_mul_busy & ~w_is_mul);
  assign w_accept    = req_valid & req_ready;
  assign w_mul_issue = w_accept & w_is_mul;
  assign w_issue_tag = '{rd_addr: req_info.rd_addr, pc: req_pc};

  always_comb begin
    w_fast_rsp   = '0;
    w_fast_valid = 1'b0;
    w_br_taken   = 1'b0;
    if (w_accept) begin
      w_fast_rsp.rd_addr = req_info.rd_addr;
      case (req_info.opcode)
        OP_ADD, OP_SUB, OP_ADDI: begin
          w_fast_valid      = 1'b1;
          w_fast_rsp.r_type = 1'b1;
          w_fast_rsp.data   = (req_info.opcode == OP_ADD)  ? req_info.ra_data + req_info.rb_data :
                              (req_info.opcode == OP_SUB)  ? req_info.ra_data - req_info.rb_data :
                                                             req_info.ra_data + w_imm;
        end
        OP_LDB, OP_LDW, OP_STB, OP_STW: begin
          w_fast_valid        = 1'b1;
          w_fast_rsp.m_type   = 1'b1;
          w_fast_rsp.addr     = req_info.ra_data + w_imm;
          w_fast_rsp.data     = req_info.rb_data;
          w_fast_rsp.is_store = (req_info.opcode == OP_STB) || (req_info.opcode == OP_STW);
          w_fast_rsp.size     = ((req_info.opcode == OP_LDB) || (req_info.opcode == OP_STB)) ?
                                SZ_BYTE : SZ_WORD;
        end
        OP_BEQ:  w_br_taken = (req_info.ra_data == req_info.rb_data);
        OP_JUMP: w_br_taken = 1'b1;
        default: w_br_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_mul_rsp         = '0;
    w_mul_rsp.data    = w_mul_data;
    w_mul_rsp.rd_addr = w_mul_tag.rd_addr;
    w_mul_rsp.r_type  = 1'b1;
  end

  alu_mul_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (MUL_LATENCY),
    .TAG_T      (mul_tag_t)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .i_en    (~stall_in),
    .i_flush (flush),
    .i_valid (w_mul_issue),
    .i_a     (req_info.ra_data),
    .i_b     (req_info.rb_data),
    .i_tag   (w_issue_tag),
    .o_valid (w_mul_valid),
    .o_data  (w_mul_data),
    .o_tag   (w_mul_tag)
  );

  // A MUL leaves the in-flight count only once its response has been taken downstream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_mul     <= 1'b0;
      r_rsp_info    <= '0;
      r_rsp_pc      <= '0;
      r_take_branch <= 1'b0;
      r_branch_pc   <= '0;
      r_inflight    <= '0;
    end else begin
      r_take_branch <= w_br_taken;
      if (w_br_taken) r_branch_pc <= PC_WIDTH'(w_offset);
      if (flush) begin
        r_rsp_valid <= 1'b0;
        r_rsp_mul   <= 1'b0;
        r_rsp_info  <= '0;
        r_rsp_pc    <= '0;
        r_inflight  <= '0;
      end else if (!stall_in) begin
        r_rsp_valid <= w_mul_valid | w_fast_valid;
        r_rsp_mul   <= w_mul_valid;
        r_rsp_info  <= w_mul_valid ? w_mul_rsp : w_fast_rsp;
        r_rsp_pc    <= w_mul_valid ? w_mul_tag.pc : req_pc;
        r_inflight  <= r_inflight + CNT_W'(w_mul_issue) - CNT_W'(r_rsp_mul);
      end
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_info       = r_rsp_info;
  assign rsp_pc         = r_rsp_pc;
  assign take_branch    = r_take_branch;
  assign branch_pc      = r_branch_pc;
  assign mul_inflight   = r_inflight;
  assign bypass_valid   = r_rsp_valid & r_rsp_info.r_type;
  assign bypass_rd_addr = r_rsp_info.rd_addr;
  assign bypass_data    = r_rsp_info.data;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe against a queue-based reference model
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int LAT = 4;
  localparam int CW  = $clog2(LAT + 1);

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           req_valid, req_ready, stall_in, flush;
  alu_req_t       req_info;
  logic [31:0]    req_pc;
  logic           rsp_valid, take_branch, bypass_valid;
  alu_rsp_t       rsp_info;
  logic [31:0]    rsp_pc, branch_pc, bypass_data;
  logic [4:0]     bypass_rd_addr;
  logic [CW-1:0]  mul_inflight;

  always #5 clock = ~clock;

  alu_pipe #(.MUL_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_info(req_info), .req_pc(req_pc), .stall_in(stall_in), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_info(rsp_info), .rsp_pc(rsp_pc),
    .take_branch(take_branch), .branch_pc(branch_pc), .bypass_valid(bypass_valid),
    .bypass_rd_addr(bypass_rd_addr), .bypass_data(bypass_data), .mul_inflight(mul_inflight)
  );

  typedef struct {
    int          rem;
    logic        is_mul;
    alu_rsp_t    rsp;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] seen[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, peak = 0, first_rsp = -1, s0;
  logic        exp_tb = 1'b0, ready_m = 1'b0;
  logic [31:0] exp_bpc = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mul_count();
    int c = 0;
    foreach (q[i]) if (q[i].is_mul) c++;
    return c;
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [19:0] off, input logic [4:0] rd, input logic st, input logic fl);
    req_valid        = v;
    req_info.opcode  = alu_op_e'(op);
    req_info.ra_data = a;
    req_info.rb_data = b;
    req_info.offset  = off;
    req_info.rd_addr = rd;
    req_pc           = $urandom;
    stall_in         = st;
    flush            = fl;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 20'd0, 5'd0, st, 1'b0);
  endtask

  task automatic observe();
    logic ev;
    ready_m = reset & !stall_in & !flush & !(mul_count() != 0 && req_info.opcode != OP_MUL);
    chk("req_ready", req_ready, ready_m);
    chk("mul_inflight", mul_inflight, mul_count());
    if (int'(mul_inflight) > peak) peak = mul_inflight;
    if (rsp_valid && first_rsp < 0) first_rsp = cyc;
    ev = (q.size() != 0) && (q[0].rem == 0);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("bypass_valid", bypass_valid, q[0].rsp.r_type);
      chk("rsp_data", rsp_info.data, q[0].rsp.data);
      chk("rsp_pc", rsp_pc, q[0].pc);
      chk("rsp_r_type", rsp_info.r_type, q[0].rsp.r_type);
      chk("rsp_m_type", rsp_info.m_type, q[0].rsp.m_type);
      if (q[0].rsp.m_type) begin
        chk("rsp_addr", rsp_info.addr, q[0].rsp.addr);
        chk("rsp_is_store", rsp_info.is_store, q[0].rsp.is_store);
        chk("rsp_size", rsp_info.size, q[0].rsp.size);
      end
      if (q[0].rsp.r_type) begin
        chk("rsp_rd_addr", rsp_info.rd_addr, q[0].rsp.rd_addr);
        chk("bypass_rd_addr", bypass_rd_addr, q[0].rsp.rd_addr);
        chk("bypass_data", bypass_data, q[0].rsp.data);
      end
      if (!stall_in) seen.push_back(rsp_info.data);
    end else begin
      chk("bypass_valid_idle", bypass_valid, 1'b0);
    end
    chk("take_branch", take_branch, exp_tb);
    if (exp_tb) chk("branch_pc", branch_pc, exp_bpc);
  endtask

  // Model: a response becomes visible after its latency in unstalled edges and is
  // consumed on the first unstalled edge while visible; flush discards everything.
  task automatic advance();
    exp_t        e;
    logic [63:0] p;
    logic [31:0] a, b, imm;
    logic        has;
    exp_tb = 1'b0;
    if (flush) q.delete();
    else if (!stall_in) begin
      if (q.size() != 0 && q[0].rem == 0) void'(q.pop_front());
      foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
    end
    if (req_valid && ready_m) begin
      a = req_info.ra_data;
      b = req_info.rb_data;
      imm = {12'h0, req_info.offset};
      e.rem = 0; e.is_mul = 1'b0; e.rsp = '0; e.pc = req_pc;
      e.rsp.rd_addr = req_info.rd_addr;
      has = 1'b1;
      if (req_info.opcode == OP_ADD) begin e.rsp.data = a + b; e.rsp.r_type = 1'b1; end
      else if (req_info.opcode == OP_SUB) begin e.rsp.data = a - b; e.rsp.r_type = 1'b1; end
      else if (req_info.opcode == OP_ADDI) begin e.rsp.data = a + imm; e.rsp.r_type = 1'b1; end
      else if (req_info.opcode == OP_MUL) begin
        p = {32'h0, a} * {32'h0, b};
        e.rsp.data = p[31:0]; e.rsp.r_type = 1'b1; e.is_mul = 1'b1; e.rem = LAT - 1;
      end else if (req_info.opcode inside {OP_LDB, OP_LDW, OP_STB, OP_STW}) begin
        e.rsp.addr = a + imm; e.rsp.data = b; e.rsp.m_type = 1'b1;
        e.rsp.is_store = req_info.opcode inside {OP_STB, OP_STW};
        e.rsp.size = (req_info.opcode inside {OP_LDB, OP_STB}) ? SZ_BYTE : SZ_WORD;
      end else begin
        has = 1'b0;
        if (req_info.opcode == OP_JUMP || (req_info.opcode == OP_BEQ && a == b)) begin
          exp_tb = 1'b1; exp_bpc = imm;
        end
      end
      if (has) q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clock);
    observe();
    cyc++;
    @(posedge clock);
    advance();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_info"}, rsp_info, '0);
    chk({tag, "_rsp_pc"}, rsp_pc, 32'd0);
    chk({tag, "_take_branch"}, take_branch, 1'b0);
    chk({tag, "_mul_inflight"}, mul_inflight, '0);
    chk({tag, "_bypass_valid"}, bypass_valid, 1'b0);
    chk({tag, "_bypass_data"}, bypass_data, 32'd0);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
  endtask

  logic [31:0] mul_exp [4] = '{32'd12, 32'd30, 32'hFFFF_FFFE, 32'd49};
  logic [31:0] mul_a   [4] = '{32'd3, 32'd5, 32'hFFFF_FFFF, 32'd7};
  logic [31:0] mul_b   [4] = '{32'd4, 32'd6, 32'd2, 32'd7};

  initial begin
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 20'd0, 5'd1, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    chk("reset_branch_pc", branch_pc, 32'd0);
    idle(1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // ADD 5+7 -> rd 3
    seen.delete();
    drive(1'b1, OP_ADD, 32'd5, 32'd7, 20'd0, 5'd3, 1'b0, 1'b0); step();
    idle(1'b0); step(); step();
    chk("add_result", (seen.size() == 1) ? seen[0] : 32'hDEAD, 32'd12);

    // Four back-to-back MULs
    seen.delete(); peak = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_MUL, mul_a[i], mul_b[i], 20'd0, 5'(i + 8), 1'b0, 1'b0); step();
    end
    idle(1'b0);
    repeat (LAT + 3) step();
    chk("mul_peak", peak, 4);
    chk("mul_count_seen", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("mul_result", (seen.size() > i) ? seen[i] : 32'hDEAD, mul_exp[i]);

    // MUL then SUB held: SUB waits for the MUL to drain
    seen.delete();
    drive(1'b1, OP_MUL, 32'd6, 32'd7, 20'd0, 5'd4, 1'b0, 1'b0); step();
    for (int i = 0; i < LAT + 4; i++) begin
      drive(1'b1, OP_SUB, 32'd10, 32'd3, 20'd0, 5'd5, 1'b0, 1'b0); step();
      if (ready_m) break;
    end
    idle(1'b0); step(); step();
    chk("order_count", seen.size(), 2);
    chk("order_first", (seen.size() > 0) ? seen[0] : 32'hDEAD, 32'd42);
    chk("order_second", (seen.size() > 1) ? seen[1] : 32'hDEAD, 32'd7);

    // Memory ops and branches
    drive(1'b1, OP_STB, 32'h100, 32'hAB, 20'h4, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, OP_LDW, 32'h2000, 32'h0, 20'hFFFFF, 5'd6, 1'b0, 1'b0); step();
    drive(1'b1, OP_BEQ, 32'd9, 32'd9, 20'h40, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, OP_BEQ, 32'd9, 32'd8, 20'h80, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, OP_JUMP, 32'd0, 32'd0, 20'h123, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, 4'd13, 32'd1, 32'd1, 20'h55, 5'd7, 1'b0, 1'b0); step();
    idle(1'b0); step(); step();

    // MUL with 3 stall cycles in flight, then stalled while visible
    first_rsp = -1; s0 = cyc;
    drive(1'b1, OP_MUL, 32'd11, 32'd13, 20'd0, 5'd9, 1'b0, 1'b0); step();
    idle(1'b0); step();
    idle(1'b1); repeat (3) step();
    idle(1'b0); repeat (2) step();
    idle(1'b1); repeat (2) step();
    idle(1'b0); repeat (2) step();
    chk("stall_latency", first_rsp - s0, LAT + 3);

    // Flush kills a MUL in flight and refuses the request offered with it
    drive(1'b1, OP_MUL, 32'd2, 32'd3, 20'd0, 5'd10, 1'b0, 1'b0); step();
    idle(1'b0); step();
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 20'd0, 5'd11, 1'b0, 1'b1); step();
    chk("flush_inflight", mul_inflight, '0);
    chk("flush_rsp_valid", rsp_valid, 1'b0);
    idle(1'b0); repeat (LAT + 2) step();

    // Asynchronous reset in the middle of a MUL
    drive(1'b1, OP_MUL, 32'd4, 32'd5, 20'd0, 5'd12, 1'b0, 1'b0); step();
    idle(1'b0); step();
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    q.delete(); exp_tb = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    repeat (LAT + 2) step();

    // Randomized traffic with stalls and occasional flushes
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 11)), a, b, 20'($urandom),
            5'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0);
      step();
    end
    idle(1'b0);
    repeat (LAT + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised successor of the single-issue integer ALU stage: sits between decode and the D$ stage, executes ADD/SUB/ADDI/MUL, generates load/store addresses and resolves BEQ/JUMP. The width, tag and multiplier latency are generics. Multiplies run in a fully pipelined multiplier that accepts one MUL per cycle instead of blocking. It keeps in-order completion through a valid/ready handshake, a downstream stall and a flush input.

## Interface
Parameters:
- DATA_WIDTH, 32: register-file data width.
- PC_WIDTH, 32: PC width.
- RF_ADDR_WIDTH, 5: register address width.
- OFFSET_WIDTH, 20: immediate width, zero-extended.
- MUL_LATENCY, 4: cycles from MUL accept to response; legal range 2..16.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- req_valid  in  1  decode offers an instruction.
- req_ready  out  1  ALU accepts this cycle; transfer = req_valid & req_ready.
- req_info  in  alu_req_t  opcode, ra_data, rb_data, offset, rd_addr.
- req_pc  in  PC_WIDTH  PC of the offered instruction.
- stall_in  in  1  D$ stage cannot take a response; freezes the block.
- flush  in  1  kill every in-flight instruction.
- rsp_valid  out  1  response valid to D$ stage.
- rsp_info  out  alu_rsp_t  data, addr, is_store, size, rd_addr, m_type, r_type.
- rsp_pc  out  PC_WIDTH  PC of the response.
- take_branch  out  1  one-cycle pulse, branch taken.
- branch_pc  out  PC_WIDTH  target; valid with take_branch.
- bypass_valid  out  1  equals rsp_valid & rsp_info.r_type.
- bypass_rd_addr  out  RF_ADDR_WIDTH  equals rsp_info.rd_addr.
- bypass_data  out  DATA_WIDTH  equals rsp_info.data.
- mul_inflight  out  ceil(log2(MUL_LATENCY+1))  count of MULs in the multiplier.

## Operation
- ADD, SUB: ra ± rb, truncated to DATA_WIDTH; r_type=1.
- ADDI: ra + ZX(offset); r_type=1.
- MUL: low DATA_WIDTH bits of ra*rb; r_type=1.
- LDB/LDW/STB/STW: addr = ra + ZX(offset), data = rb.
  - is_store=1 for STx; size=Byte for xxB, Word for xxW; m_type=1.
- BEQ: if ra==rb, take_branch=1 and branch_pc = ZX(offset).
- JUMP: always take_branch=1, branch_pc = ZX(offset).
- BEQ/JUMP produce no rsp_valid.
- Unknown opcode: accepted and dropped; no response, no branch.
- In-order rule: a non-MUL op is not accepted while mul_inflight != 0, so req_ready = !stall_in & !(mul_inflight!=0 & opcode!=MUL). Back-to-back MULs are accepted.
- stall_in=1: multiplier shift enable, output register and counters all hold. req_ready=0.
- flush=1: beats stall.
  - Next cycle: rsp_valid=0, take_branch=0, all multiplier valid bits cleared, mul_inflight=0.
  - A request offered in the same cycle is not accepted (req_ready=0).
- mul_inflight: +1 on MUL accept, −1 on MUL completion; both in one cycle leaves it unchanged. Saturation is impossible by construction (max MUL_LATENCY).

## Timing
- Fast op (ALU/mem) accepted in cycle N: rsp_valid in N+1.
- Branch accepted in N: take_branch pulse in N+1.
- MUL accepted in N: rsp_valid in N+MUL_LATENCY, plus one cycle for each stall_in cycle in between.
- A response is held stable while stall_in=1.
- Reset values: rsp_valid=0, take_branch=0, branch_pc=0, rsp_info=0, rsp_pc=0, mul_inflight=0, bypass_*=0.
- req_ready is combinational; it is 0 during reset.
- Reset asserted mid-MUL: everything is lost. First possible accept is the first edge after deassertion.

## Structure
- Package alu_pkg holds:
  - opcode constants and alu_op_e;
  - alu_req_t and alu_rsp_t;
  - the size enum (Byte/Word).
- Sub-module alu_mul_pipe (DATA_WIDTH, LATENCY, TAG_T):
  - MUL_LATENCY−1 register stages after the input stage;
  - carries a valid bit and a tag (rd_addr, pc) per stage;
  - inputs: enable, flush.
- The top contains the fast path, the branch unit, the output mux (MUL completion vs fast op, mutually exclusive by the in-order rule) and the counter.

## Test plan
- ADD ra=5, rb=7, rd=3 -> next cycle rsp_valid=1, data=12, r_type=1, bypass_rd_addr=3.
- Four back-to-back MULs, MUL_LATENCY=4 (3*4, 5*6, 0xFFFFFFFF*2, 7*7) -> responses 12, 30, 0xFFFFFFFE, 49 in cycles 4-7; mul_inflight peaks at 4.
- MUL then SUB offered the next cycle -> req_ready=0 until the MUL completes; SUB response follows the MUL response.
- STB ra=0x100, offset=4, rb=0xAB -> addr=0x104, data=0xAB, is_store=1, size=Byte, m_type=1.
- BEQ ra=rb=9, offset=0x40 -> take_branch pulse one cycle, branch_pc=0x40. With ra≠rb -> no pulse.
- MUL in flight with stall_in held 3 cycles -> response delayed 3 cycles and held stable. Then flush during a second MUL -> no response, mul_inflight=0 next cycle.
- Reset pulled low mid-MUL -> all outputs 0 immediately; no stale response after release.
